// File: rtl/demux1x2_8bits_pkg.sv
// Shared definitions for the 1-to-2 lane demux.
//   phase_t      : framing FSM encoding, shared with the mux bench so loopback
//                  alignment can be reasoned about with the same names
//   SKIP_DEFAULT : default number of IDLE cycles after reset release
//   lane_data()  : output-side zeroing of words whose valid bit is low
package demux1x2_8bits_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2
    } phase_t;

    localparam int SKIP_DEFAULT = 2;
    localparam int SKIP_W       = 4;   // holds SKIP-1 for SKIP in 0..15

    function automatic logic [7:0] lane_data(input logic [7:0] data,
                                             input logic       valid,
                                             input logic       zero_invalid);
        return (zero_invalid && !valid) ? 8'h00 : data;
    endfunction

endpackage

// File: rtl/demux1x2_8bits_phase_gen_2f.sv
// Framing generator for the demux: waits SKIP cycles after reset release,
// then alternates LANE0/LANE1 forever.
//
//   state | meaning
//   IDLE  | counting off upstream pipeline latency after reset
//   LANE0 | current input word is lane 0; it is captured into the hold register
//   LANE1 | current input word is lane 1; both lanes load the output registers
//
// Ports:
//   clk_4f  in   serial word clock
//   reset   in   asynchronous, active-low
//   phase   out  current framing state
//   sync    out  high from the edge that leaves IDLE until reset
//   stb_2f  out  one-cycle pulse in the first cycle of each new lane pair
module demux1x2_8bits_phase_gen_2f
    import demux1x2_8bits_pkg::*;
#(
    parameter int SKIP = SKIP_DEFAULT
) (
    input  logic   clk_4f,
    input  logic   reset,
    output phase_t phase,
    output logic   sync,
    output logic   stb_2f
);

    // SKIP=0 collapses onto the same compare as SKIP=1: leave IDLE on the
    // first edge after release.
    localparam logic [SKIP_W-1:0] SKIP_LAST = (SKIP == 0) ? '0 : SKIP_W'(SKIP - 1);

    logic [SKIP_W-1:0] skip_cnt;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            phase    <= IDLE;
            skip_cnt <= '0;
            sync     <= 1'b0;
            stb_2f   <= 1'b0;
        end else begin
            stb_2f <= 1'b0;
            case (phase)
                IDLE: begin
                    if (skip_cnt == SKIP_LAST) begin
                        phase <= LANE0;
                        sync  <= 1'b1;
                    end else begin
                        skip_cnt <= skip_cnt + 1'b1;
                    end
                end
                LANE0: phase <= LANE1;
                LANE1: begin
                    phase  <= LANE0;
                    stb_2f <= 1'b1;
                end
                default: phase <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/demux1x2_8bits.sv
// 1-serial-lane to 2-parallel-lane 8-bit demux. Lane 0 arrives first on the
// serial stream, is parked in a hold register, and is presented together with
// the following lane-1 word for two clk_4f cycles.
//
// Ports:
//   clk_4f     in   serial word clock
//   reset      in   asynchronous, active-low
//   data_000   in   serial data word
//   valid_000  in   serial valid
//   data_00    out  lane 0 data
//   valid_00   out  lane 0 valid
//   data_11    out  lane 1 data
//   valid_11   out  lane 1 valid
//   stb_2f     out  pulse in the first cycle of each new lane pair
//   sync       out  framing has left IDLE
module demux1x2_8bits
    import demux1x2_8bits_pkg::*;
#(
    parameter int SKIP         = SKIP_DEFAULT,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_000,
    input  logic       valid_000,
    output logic [7:0] data_00,
    output logic       valid_00,
    output logic [7:0] data_11,
    output logic       valid_11,
    output logic       stb_2f,
    output logic       sync
);

    phase_t     phase;
    logic [7:0] hold_data;
    logic       hold_valid;

    demux1x2_8bits_phase_gen_2f #(
        .SKIP (SKIP)
    ) u_phase_gen (
        .clk_4f (clk_4f),
        .reset  (reset),
        .phase  (phase),
        .sync   (sync),
        .stb_2f (stb_2f)
    );

    // Hold keeps the raw word; zeroing happens only on the output load so the
    // valid bit and data stay paired exactly as received until presentation.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            hold_data  <= 8'h00;
            hold_valid <= 1'b0;
            data_00    <= 8'h00;
            valid_00   <= 1'b0;
            data_11    <= 8'h00;
            valid_11   <= 1'b0;
        end else begin
            if (phase == LANE0) begin
                hold_data  <= data_000;
                hold_valid <= valid_000;
            end
            if (phase == LANE1) begin
                data_00  <= lane_data(hold_data, hold_valid, ZERO_INVALID);
                valid_00 <= hold_valid;
                data_11  <= lane_data(data_000, valid_000, ZERO_INVALID);
                valid_11 <= valid_000;
            end
        end
    end

endmodule

// File: tb/tb_demux1x2_8bits.sv
// Bench for demux1x2_8bits: three instances share one stimulus stream
//   dut_a  : SKIP=2, zeroing on
//   dut_nz : SKIP=2, zeroing off
//   dut_s0 : SKIP=0, zeroing on
// Expected lane pairs are queued when the lane-1 word is driven and popped
// when the instance strobes.
module tb_demux1x2_8bits;

    localparam int SYNC_A = 2;   // SKIP=2: leaves IDLE on edge 2 after release
    localparam int SYNC_B = 1;   // SKIP=0: leaves IDLE on edge 1 after release

    typedef struct packed {
        logic [7:0] d0;
        logic       v0;
        logic [7:0] d1;
        logic       v1;
    } pair_t;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_000 = 8'h00;
    logic       valid_000 = 1'b0;

    logic [7:0] d00_a, d11_a, d00_nz, d11_nz, d00_s0, d11_s0;
    logic       v00_a, v11_a, v00_nz, v11_nz, v00_s0, v11_s0;
    logic       stb_a, stb_nz, stb_s0, sync_a, sync_nz, sync_s0;

    demux1x2_8bits #(.SKIP(2), .ZERO_INVALID(1'b1)) dut_a (
        .clk_4f(clk_4f), .reset(reset), .data_000(data_000), .valid_000(valid_000),
        .data_00(d00_a), .valid_00(v00_a), .data_11(d11_a), .valid_11(v11_a),
        .stb_2f(stb_a), .sync(sync_a));

    demux1x2_8bits #(.SKIP(2), .ZERO_INVALID(1'b0)) dut_nz (
        .clk_4f(clk_4f), .reset(reset), .data_000(data_000), .valid_000(valid_000),
        .data_00(d00_nz), .valid_00(v00_nz), .data_11(d11_nz), .valid_11(v11_nz),
        .stb_2f(stb_nz), .sync(sync_nz));

    demux1x2_8bits #(.SKIP(0), .ZERO_INVALID(1'b1)) dut_s0 (
        .clk_4f(clk_4f), .reset(reset), .data_000(data_000), .valid_000(valid_000),
        .data_00(d00_s0), .valid_00(v00_s0), .data_11(d11_s0), .valid_11(v11_s0),
        .stb_2f(stb_s0), .sync(sync_s0));

    always #5 clk_4f = ~clk_4f;

    int errors = 0;
    int checks = 0;

    int         edge_cnt = 0;
    logic [7:0] hd_a = 8'h00, hd_b = 8'h00;
    logic       hv_a = 1'b0, hv_b = 1'b0;
    pair_t      cur_a = '0, cur_b = '0;
    pair_t      sb_a[$];
    pair_t      sb_b[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] zi(input logic [7:0] d, input logic v);
        return v ? d : 8'h00;
    endfunction

    // 0: IDLE edge, 1: lane-0 capture edge, 2: lane-1 load edge
    function automatic int phase_of(input int e, input int sync_edge);
        int k;
        k = e - sync_edge;
        if (k >= 1 && (k % 2) == 1) return 1;
        if (k >= 2 && (k % 2) == 0) return 2;
        return 0;
    endfunction

    task automatic check_outputs();
        check_eq("a_data_00",  d00_a,  zi(cur_a.d0, cur_a.v0));
        check_eq("a_valid_00", v00_a,  cur_a.v0);
        check_eq("a_data_11",  d11_a,  zi(cur_a.d1, cur_a.v1));
        check_eq("a_valid_11", v11_a,  cur_a.v1);
        check_eq("nz_data_00", d00_nz, cur_a.d0);
        check_eq("nz_valid_00", v00_nz, cur_a.v0);
        check_eq("nz_data_11", d11_nz, cur_a.d1);
        check_eq("nz_valid_11", v11_nz, cur_a.v1);
        check_eq("s0_data_00", d00_s0, zi(cur_b.d0, cur_b.v0));
        check_eq("s0_valid_00", v00_s0, cur_b.v0);
        check_eq("s0_data_11", d11_s0, zi(cur_b.d1, cur_b.v1));
        check_eq("s0_valid_11", v11_s0, cur_b.v1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_a"},  {d00_a, v00_a, d11_a, v11_a, stb_a, sync_a}, 0);
        check_eq({tag, "_nz"}, {d00_nz, v00_nz, d11_nz, v11_nz, stb_nz, sync_nz}, 0);
        check_eq({tag, "_s0"}, {d00_s0, v00_s0, d11_s0, v11_s0, stb_s0, sync_s0}, 0);
    endtask

    task automatic clear_model();
        edge_cnt = 0;
        hd_a = 8'h00; hv_a = 1'b0; hd_b = 8'h00; hv_b = 1'b0;
        cur_a = '0; cur_b = '0;
        sb_a.delete(); sb_b.delete();
    endtask

    // Drive one serial word, let one edge happen, check everything 1 ns later.
    task automatic cycle(input logic [7:0] d, input logic v);
        int    ka, kb;
        pair_t p;
        data_000 = d;
        valid_000 = v;
        edge_cnt++;
        ka = phase_of(edge_cnt, SYNC_A);
        kb = phase_of(edge_cnt, SYNC_B);
        if (ka == 1) begin hd_a = d; hv_a = v; end
        if (ka == 2) begin p = '{d0: hd_a, v0: hv_a, d1: d, v1: v}; sb_a.push_back(p); end
        if (kb == 1) begin hd_b = d; hv_b = v; end
        if (kb == 2) begin p = '{d0: hd_b, v0: hv_b, d1: d, v1: v}; sb_b.push_back(p); end
        @(posedge clk_4f);
        #1;
        check_eq("sync_a",  sync_a,  edge_cnt >= SYNC_A);
        check_eq("sync_nz", sync_nz, edge_cnt >= SYNC_A);
        check_eq("sync_s0", sync_s0, edge_cnt >= SYNC_B);
        check_eq("stb_a",   stb_a,   ka == 2);
        check_eq("stb_nz",  stb_nz,  ka == 2);
        check_eq("stb_s0",  stb_s0,  kb == 2);
        if (stb_a) begin
            if (sb_a.size() == 0) check_eq("sb_a_underflow", 1, 0);
            else cur_a = sb_a.pop_front();
        end
        if (stb_s0) begin
            if (sb_b.size() == 0) check_eq("sb_b_underflow", 1, 0);
            else cur_b = sb_b.pop_front();
        end
        check_outputs();
    endtask

    task automatic align_lane0_a();
        while (phase_of(edge_cnt + 1, SYNC_A) != 1) cycle(8'h00, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk_4f);
        #1;
        clear_model();
        reset = 1'b1;
    endtask

    initial begin
        // Reset held with active input: nothing may move.
        data_000 = 8'hFF;
        valid_000 = 1'b1;
        #3;
        check_zero("reset_hold_pre_edge");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_4f);
            #1;
            check_zero("reset_hold");
        end

        // Release with constant FF/valid stream.
        release_reset();
        for (int i = 0; i < 6; i++) cycle(8'hFF, 1'b1);

        // Directed pairs A1/B1, A2/B2.
        align_lane0_a();
        cycle(8'hA1, 1'b1);
        cycle(8'hB1, 1'b1);
        check_eq("pair1_d00", d00_a, 8'hA1);
        check_eq("pair1_d11", d11_a, 8'hB1);
        cycle(8'hA2, 1'b1);
        check_eq("pair1_hold_d00", d00_a, 8'hA1);
        cycle(8'hB2, 1'b1);
        check_eq("pair2_d00", d00_a, 8'hA2);
        check_eq("pair2_d11", d11_a, 8'hB2);

        // Invalid lane-0 word: zeroed only where zeroing is enabled.
        align_lane0_a();
        cycle(8'h5A, 1'b0);
        cycle(8'h3C, 1'b1);
        check_eq("inv_a_valid_00", v00_a, 1'b0);
        check_eq("inv_a_data_00",  d00_a, 8'h00);
        check_eq("inv_a_data_11",  d11_a, 8'h3C);
        check_eq("inv_nz_data_00", d00_nz, 8'h5A);
        cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b0);

        // Random stream, 1000 lane pairs.
        for (int i = 0; i < 2000; i++) cycle(8'($urandom), 1'($urandom));

        // Reset asserted mid-LANE1 with a lane-0 word parked in hold.
        align_lane0_a();
        cycle(8'hC3, 1'b1);
        data_000 = 8'hE7;
        valid_000 = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset_pre_edge");
        @(posedge clk_4f);
        #1;
        check_zero("async_reset_edge");
        release_reset();
        // New words stay below 8'h80 so the discarded C3 cannot reappear by chance.
        for (int i = 0; i < 16; i++) cycle(8'($urandom_range(0, 127)), 1'b1);
        check_eq("no_stale_c3", d00_a == 8'hC3, 1'b0);

        check_eq("sb_a_drained", sb_a.size(), 0);
        check_eq("sb_b_drained", sb_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
